// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle RV32I core: FSM states, opcodes
// and the select/operation encodings seen by the ALU decoder and datapath muxes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
    localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;
    localparam logic [1:0] ALU_SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] ALU_SRC_B_RS2   = 2'b00;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_READDATA  = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    // First state after DECODE; unknown opcodes go back to FETCH.
    function automatic state_t decode_target(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR1;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_FETCH;
        endcase
    endfunction

    function automatic logic is_known_op(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access has been waiting and flags the
// last allowed cycle; MEM_TIMEOUT of 0 disables the abort entirely.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + TW'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (count_reg == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences PC, IR, ALU and the
// shared memory port, with a timeout abort on stalled memory accesses.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       alu_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal_op,
    output logic       bus_err
);

    state_t state_reg;
    state_t state_next;
    logic   run_reg;
    logic   in_mem;
    logic   timer_expired;
    logic   timeout;

    // run_reg keeps every output low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            run_reg   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                state_reg <= state_next;
            end
        end
    end

    assign in_mem  = run_reg && is_mem_state(state_reg);
    assign timeout = in_mem && !mem_ready && timer_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_mem || mem_ready || timeout),
        .tick    (in_mem && !mem_ready),
        .expired (timer_expired)
    );

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:    if (mem_ready) state_next = S_DECODE;
                S_DECODE:   state_next = decode_target(op);
                S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
                S_MEMWB:    state_next = S_FETCH;
                S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI, S_AUIPC:
                            state_next = S_ALUWB;
                S_JALR1:    state_next = S_JALR2;
                S_ALUWB:    state_next = S_FETCH;
                S_BRANCH:   state_next = S_FETCH;
                default:    state_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = ALU_SRC_A_PC;
        alu_src_b  = ALU_SRC_B_RS2;
        result_src = RESULT_ALUOUT;
        alu_op     = ALU_OP_ADD;
        retire     = 1'b0;
        illegal_op = 1'b0;
        bus_err    = timeout;
        if (run_reg) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = ALU_SRC_A_PC;
                    alu_src_b  = ALU_SRC_B_FOUR;
                    result_src = RESULT_ALURESULT;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a  = ALU_SRC_A_OLDPC;
                    alu_src_b  = ALU_SRC_B_IMM;
                    illegal_op = !is_known_op(op);
                end
                S_MEMADR: begin
                    alu_src_a = ALU_SRC_A_RS1;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RESULT_READDATA;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    retire    = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = ALU_SRC_A_RS1;
                    alu_src_b = ALU_SRC_B_RS2;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = ALU_SRC_A_RS1;
                    alu_src_b = ALU_SRC_B_IMM;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = ALU_SRC_A_RS1;
                    alu_src_b = ALU_SRC_B_RS2;
                    alu_op    = ALU_OP_BRANCH;
                    pc_write  = alu_flag;
                    retire    = 1'b1;
                end
                S_JAL, S_JALR2: begin
                    alu_src_a = ALU_SRC_A_OLDPC;
                    alu_src_b = ALU_SRC_B_FOUR;
                    pc_write  = 1'b1;
                end
                // The ALU decoder clears bit 0 of the jump target in this state.
                S_JALR1: begin
                    alu_src_a = ALU_SRC_A_RS1;
                    alu_src_b = ALU_SRC_B_IMM;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_LUI: begin
                    alu_src_a = ALU_SRC_A_ZERO;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                S_AUIPC: begin
                    alu_src_a = ALU_SRC_A_OLDPC;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized scoreboard bench for multicycle_ctrl_fsm: per-instruction activity
// profiles from an instruction-level model, compared when the FSM retires or aborts.
module tb_multicycle_ctrl_fsm;

    localparam int T  = 4;
    localparam int NF = 18;
    localparam int F_KIND = 0,  F_LAT = 1,  F_IR = 2,  F_PC = 3,  F_REG = 4,  F_REQ = 5;
    localparam int F_ADR  = 6,  F_WR  = 7,  F_WRDY = 8, F_ALUF = 9, F_ALUB = 10, F_A1 = 11;
    localparam int F_A2   = 12, F_A3  = 13, F_B1 = 14, F_B2 = 15, F_RS1 = 16, F_RS2 = 17;

    typedef logic [NF-1:0][15:0] rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       alu_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       retire, illegal_op, bus_err;
    logic [16:0] outs;

    int   checks = 0;
    int   fails = 0;
    rec_t sb_q[$];
    logic in_instr = 1'b0;

    logic [6:0] op_tab [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b0000000, 7'b1111111};

    // Directed cases: opcode, alu_flag, fetch wait, memory wait.
    int d_op [14] = '{7'b0110011, 7'b0000011, 7'b1100011, 7'b1100011, 7'b0100011,
                      7'b0100011, 7'b0000000, 7'b1100111, 7'b0110011, 7'b0000011,
                      7'b1101111, 7'b0110111, 7'b0010111, 7'b0010011};
    int d_fl [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int d_wf [14] = '{0, 3, 0, 0, 0, 0, 0, 0, 4, 1, 0, 2, 0, 0};
    int d_wm [14] = '{0, 2, 0, 0, 4, 3, 0, 0, 0, 5, 0, 0, 0, 0};

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .alu_flag   (alu_flag),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .retire     (retire),
        .illegal_op (illegal_op),
        .bus_err    (bus_err)
    );

    assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, retire, illegal_op, bus_err};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic string fname(input int i);
        case (i)
            F_KIND: return "event_kind";      F_LAT:  return "latency";
            F_IR:   return "ir_write_count";  F_PC:   return "pc_write_count";
            F_REG:  return "reg_write_count"; F_REQ:  return "mem_req_cycles";
            F_ADR:  return "adr_src_cycles";  F_WR:   return "mem_write_cycles";
            F_WRDY: return "store_accepts";   F_ALUF: return "alu_op_funct_cycles";
            F_ALUB: return "alu_op_branch_cycles"; F_A1: return "src_a_oldpc_cycles";
            F_A2:   return "src_a_rs1_cycles"; F_A3:  return "src_a_zero_cycles";
            F_B1:   return "src_b_imm_cycles"; F_B2:  return "src_b_four_cycles";
            F_RS1:  return "result_readdata_cycles"; default: return "result_aluresult_cycles";
        endcase
    endfunction

    // 1 load, 2 store, 3 R, 4 I, 5 branch, 6 jal, 7 jalr, 8 lui, 9 auipc, 0 illegal
    function automatic int op_class(input logic [6:0] o);
        case (o)
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b0110011: return 3;
            7'b0010011: return 4;
            7'b1100011: return 5;
            7'b1101111: return 6;
            7'b1100111: return 7;
            7'b0110111: return 8;
            7'b0010111: return 9;
            default:    return 0;
        endcase
    endfunction

    // Instruction-level profile: event kind (1 retire, 2 bus error, 4 illegal),
    // cycle count and how many cycles each control signal/select is active.
    function automatic rec_t model(input logic [6:0] o, input int flag, input int wf, input int wm);
        int   e [NF];
        rec_t r;
        int   fe, me, cls;
        foreach (e[i]) e[i] = 0;
        fe = (wf < T) ? wf + 1 : T;
        e[F_REQ] = fe;
        e[F_B2]  = fe;
        e[F_RS2] = fe;
        if (wf >= T) begin
            e[F_KIND] = 2;
            e[F_LAT]  = T;
        end else begin
            e[F_IR] = 1; e[F_PC] = 1; e[F_A1] = 1; e[F_B1] = 1;
            e[F_KIND] = 1;
            cls = op_class(o);
            case (cls)
                0: begin e[F_KIND] = 4; e[F_LAT] = fe + 1; end
                3, 4: begin
                    e[F_LAT] = fe + 3; e[F_A2]++; e[F_ALUF]++; e[F_REG] = 1;
                    if (cls == 4) e[F_B1]++;
                end
                8: begin e[F_LAT] = fe + 3; e[F_A3] = 1; e[F_B1]++; e[F_REG] = 1; end
                9: begin e[F_LAT] = fe + 3; e[F_A1]++; e[F_B1]++; e[F_REG] = 1; end
                6: begin e[F_LAT] = fe + 3; e[F_A1]++; e[F_B2]++; e[F_PC]++; e[F_REG] = 1; end
                7: begin
                    e[F_LAT] = fe + 4; e[F_A2]++; e[F_B1]++; e[F_ALUF]++;
                    e[F_A1]++; e[F_B2]++; e[F_PC]++; e[F_REG] = 1;
                end
                5: begin e[F_LAT] = fe + 2; e[F_A2]++; e[F_ALUB] = 1; e[F_PC] += flag; end
                default: begin
                    e[F_A2]++; e[F_B1]++;
                    me = (wm < T) ? wm + 1 : T;
                    e[F_REQ] += me;
                    e[F_ADR] = me;
                    if (cls == 2) e[F_WR] = me;
                    if (wm >= T) begin
                        e[F_KIND] = 2; e[F_LAT] = fe + 2 + me;
                    end else if (cls == 1) begin
                        e[F_LAT] = fe + 3 + me; e[F_REG] = 1; e[F_RS1] = 1;
                    end else begin
                        e[F_LAT] = fe + 2 + me; e[F_WRDY] = 1;
                    end
                end
            endcase
        end
        for (int i = 0; i < NF; i++) r[i] = 16'(e[i]);
        return r;
    endfunction

    task automatic run_instr(input logic [6:0] o, input int flag, input int wf, input int wm);
        rec_t r;
        int   lat, fe, ms, me, rdy_f, rdy_m;
        bit   memop, is_mem;
        r     = model(o, flag, wf, wm);
        lat   = int'(r[F_LAT]);
        fe    = (wf < T) ? wf + 1 : T;
        ms    = fe + 2;
        me    = (wm < T) ? wm + 1 : T;
        memop = (wf < T) && (op_class(o) == 1 || op_class(o) == 2);
        rdy_f = (wf < T) ? wf : -1;
        rdy_m = (memop && wm < T) ? ms + wm : -1;
        sb_q.push_back(r);
        $display("issue op=%07b flag=%0d fetch_wait=%0d mem_wait=%0d expect_kind=%0d latency=%0d",
                 o, flag, wf, wm, int'(r[F_KIND]), lat);
        for (int c = 0; c < lat; c++) begin
            @(posedge clk);
            #1;
            in_instr = 1'b1;
            alu_flag = flag[0];
            op = (c < fe) ? 7'($urandom) : o;
            is_mem = (c < fe) || (memop && c >= ms && c < ms + me);
            if (is_mem) mem_ready = (c == rdy_f) || (c == rdy_m);
            else        mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin : monitor
        int   act [NF];
        rec_t exp_r;
        foreach (act[i]) act[i] = 0;
        forever begin
            @(negedge clk);
            if (in_instr && reset_n) begin
                act[F_LAT]++;
                act[F_IR]   += int'(ir_write);
                act[F_PC]   += int'(pc_write);
                act[F_REG]  += int'(reg_write);
                act[F_REQ]  += int'(mem_req);
                act[F_ADR]  += int'(adr_src);
                act[F_WR]   += int'(mem_write);
                act[F_WRDY] += int'(mem_write && mem_ready);
                act[F_ALUF] += int'(alu_op == 2'b10);
                act[F_ALUB] += int'(alu_op == 2'b01);
                act[F_A1]   += int'(alu_src_a == 2'b01);
                act[F_A2]   += int'(alu_src_a == 2'b10);
                act[F_A3]   += int'(alu_src_a == 2'b11);
                act[F_B1]   += int'(alu_src_b == 2'b01);
                act[F_B2]   += int'(alu_src_b == 2'b10);
                act[F_RS1]  += int'(result_src == 2'b01);
                act[F_RS2]  += int'(result_src == 2'b10);
                if (retire || bus_err || illegal_op) begin
                    act[F_KIND] = int'({illegal_op, bus_err, retire});
                    if (sb_q.size() == 0) begin
                        check("unexpected_event", act[F_KIND], 0);
                    end else begin
                        exp_r = sb_q.pop_front();
                        for (int i = 0; i < NF; i++) check(fname(i), act[i], int'(exp_r[i]));
                        $display("event kind=%0d latency=%0d checked", act[F_KIND], act[F_LAT]);
                    end
                    foreach (act[i]) act[i] = 0;
                end else if (act[F_LAT] > 40) begin
                    check("instruction_timeout", act[F_LAT], 0);
                    foreach (act[i]) act[i] = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int idx;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            op = 7'($urandom);
            #1;
            check("reset_outputs_zero", int'(outs), 0);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) run_instr(7'(d_op[i]), d_fl[i], d_wf[i], d_wm[i]);
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, 10);
            run_instr(op_tab[idx], $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 5));
        end
        @(negedge clk);
        #1;
        in_instr = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);

        // Load stalled in MEMREAD, then reset asserted mid-instruction.
        @(posedge clk); #1; op = 7'b0000011; mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("memread_mem_req", int'(mem_req), 1);
        check("memread_adr_src", int'(adr_src), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs_zero", int'(outs), 0);
        @(negedge clk);
        check("held_reset_outputs_zero", int'(outs), 0);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        check("post_reset_mem_req", int'(mem_req), 1);
        check("post_reset_adr_src", int'(adr_src), 0);
        check("post_reset_reg_write", int'(reg_write), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
